// File: rtl/sipo_pkg.sv
// Shared definitions for the SIPO deframer: counter width helper and
// output-register state encoding.
package sipo_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    function automatic int cnt_w(input int width);
        int w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : sipo_pkg

// File: rtl/sipo_shift_core.sv
// Serial shift register with qualified input, frame-position counter and a
// completion strobe that presents the finished word in the same cycle.
module sipo_shift_core
    import sipo_pkg::*;
#(
    parameter int  WIDTH     = 8,
    parameter bit  MSB_FIRST = 1'b1,
    localparam int CNT_W     = cnt_w(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             d_valid,
    input  logic             d_in,
    output logic [WIDTH-1:0] word,
    output logic             done,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] sh;
    logic             last;

    // NOTE: every combinational output gets a value on every path; a missing
    // assignment here would silently infer a latch.
    always_comb begin
        word = '0;
        if (MSB_FIRST) begin
            word = {sh[WIDTH-2:0], d_in};
        end else begin
            word = {d_in, sh[WIDTH-1:1]};
        end
    end

    assign last = (bit_cnt == LAST);
    assign done = d_valid && last && !clear;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sh      <= '0;
            bit_cnt <= '0;
        end else if (clear) begin
            sh      <= '0;
            bit_cnt <= '0;
        end else if (d_valid) begin
            if (last) begin
                // The completed word leaves through 'word'; start the next frame clean.
                sh      <= '0;
                bit_cnt <= '0;
            end else begin
                sh      <= word;
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

endmodule : sipo_shift_core

// File: rtl/sipo_framer.sv
// Parametrised serial-in/parallel-out deframer with a valid/ready output
// register and sticky overrun flag.
module sipo_framer
    import sipo_pkg::*;
#(
    parameter int  WIDTH     = 8,
    parameter bit  MSB_FIRST = 1'b1,
    localparam int CNT_W     = cnt_w(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             d_valid,
    input  logic             d_in,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d_out,
    output logic             out_valid,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             overrun
);

    if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
        $fatal(1, "sipo_framer: WIDTH must be in 2..64");
    end

    logic [WIDTH-1:0] word;
    logic             done;
    out_state_t       state;
    out_state_t       next_state;
    logic             overrun_set;

    sipo_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clock   (clock),
        .reset   (reset),
        .clear   (clear),
        .d_valid (d_valid),
        .d_in    (d_in),
        .word    (word),
        .done    (done),
        .bit_cnt (bit_cnt)
    );

    // A completion always wins over a pop; it only loses data if nobody
    // takes the word that is still sitting in the register.
    always_comb begin
        next_state  = state;
        overrun_set = 1'b0;
        if (done) begin
            next_state = FULL;
            if (state == FULL && !out_ready) begin
                overrun_set = 1'b1;
            end
        end else if (state == FULL && out_ready) begin
            next_state = EMPTY;
        end
    end

    // NOTE: all state, including the data register, is reset so no stale
    // word can ever appear after reset release.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
        end else if (clear) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            d_out   <= '0;
            overrun <= 1'b0;
        end else if (clear) begin
            d_out   <= '0;
            overrun <= 1'b0;
        end else begin
            if (done) begin
                d_out <= word;
            end
            if (overrun_set) begin
                overrun <= 1'b1;
            end
        end
    end

    assign out_valid = (state == FULL);

endmodule : sipo_framer

// File: tb/tb_sipo_framer.sv
// Scoreboard bench: stimulus pushes expected words, monitors pop them on
// each accepted handshake of an MSB-first and an LSB-first instance.
module tb_sipo_framer;

    logic       clock;
    logic       reset;
    logic       clear;
    logic       d_valid;
    logic       d_in;
    logic       out_ready;
    logic [7:0] d_out_m, d_out_l;
    logic       out_valid_m, out_valid_l;
    logic [2:0] bit_cnt_m, bit_cnt_l;
    logic       overrun_m, overrun_l;

    int passed = 0;
    int total  = 0;

    logic [7:0] q_m[$];
    logic [7:0] q_l[$];

    sipo_framer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .d_valid   (d_valid),
        .d_in      (d_in),
        .out_ready (out_ready),
        .d_out     (d_out_m),
        .out_valid (out_valid_m),
        .bit_cnt   (bit_cnt_m),
        .overrun   (overrun_m)
    );

    sipo_framer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .d_valid   (d_valid),
        .d_in      (d_in),
        .out_ready (out_ready),
        .d_out     (d_out_l),
        .out_valid (out_valid_l),
        .bit_cnt   (bit_cnt_l),
        .overrun   (overrun_l)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // Monitors: one pop per accepted word on each instance.
    initial begin
        forever begin
            @(negedge clock);
            if (out_valid_m && out_ready) begin
                if (q_m.size() == 0) begin
                    check("msb_unexpected_word", {56'd0, d_out_m}, 64'hFFFF);
                end else begin
                    check("msb_word", {56'd0, d_out_m}, {56'd0, q_m.pop_front()});
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (out_valid_l && out_ready) begin
                if (q_l.size() == 0) begin
                    check("lsb_unexpected_word", {56'd0, d_out_l}, 64'hFFFF);
                end else begin
                    check("lsb_word", {56'd0, d_out_l}, {56'd0, q_l.pop_front()});
                end
            end
        end
    end

    task automatic send_bit(input logic b);
        d_valid = 1'b1;
        d_in    = b;
        @(posedge clock);
        #1;
        d_valid = 1'b0;
        d_in    = 1'b0;
    endtask

    // Sends a word MSB first on the wire; LSB instance sees it bit-reversed.
    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic expect_word(input logic [7:0] w);
        q_m.push_back(w);
        q_l.push_back(rev8(w));
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    logic [7:0] pat;

    initial begin
        reset     = 1'b0;
        clear     = 1'b0;
        d_valid   = 1'b0;
        d_in      = 1'b0;
        out_ready = 1'b0;
        idle(2);
        check("reset_d_out", {56'd0, d_out_m}, 64'h0);
        check("reset_valid", {63'd0, out_valid_m}, 64'h0);
        check("reset_cnt", {61'd0, bit_cnt_m}, 64'h0);
        check("reset_overrun", {63'd0, overrun_m}, 64'h0);
        reset = 1'b1;
        idle(1);

        // MSB-first / LSB-first word: bits 1,1,1,0,1,1,0,1.
        pat = 8'hED;
        for (int i = 7; i >= 1; i--) send_bit(pat[i]);
        check("w1_cnt_before_last", {61'd0, bit_cnt_m}, 64'd7);
        check("w1_valid_before_last", {63'd0, out_valid_m}, 64'h0);
        expect_word(8'hED);
        send_bit(pat[0]);
        check("w1_valid_rise", {63'd0, out_valid_m}, 64'h1);
        check("w1_msb_d_out", {56'd0, d_out_m}, 64'hED);
        check("w1_lsb_d_out", {56'd0, d_out_l}, 64'hB7);
        check("w1_overrun", {63'd0, overrun_m}, 64'h0);
        check("w1_cnt_wrap", {61'd0, bit_cnt_m}, 64'h0);
        consume();
        check("w1_valid_after_pop", {63'd0, out_valid_m}, 64'h0);
        check("w1_d_out_holds", {56'd0, d_out_m}, 64'hED);
        // Ready while empty must not disturb anything.
        consume();
        check("ready_while_empty", {63'd0, out_valid_l}, 64'h0);

        // Gapped input: 3 idle cycles between bits 4 and 5.
        for (int i = 7; i >= 4; i--) send_bit(pat[i]);
        for (int g = 0; g < 3; g++) begin
            idle(1);
            check("gap_cnt_hold", {61'd0, bit_cnt_m}, 64'd4);
        end
        expect_word(8'hED);
        for (int i = 3; i >= 0; i--) send_bit(pat[i]);
        check("gap_d_out", {56'd0, d_out_m}, 64'hED);
        consume();

        // Overrun: A5 then 3C, never consumed in between.
        send_word(8'hA5);
        check("ovr_first_valid", {63'd0, out_valid_m}, 64'h1);
        check("ovr_first_no_ovr", {63'd0, overrun_m}, 64'h0);
        send_word(8'h3C);
        check("ovr_d_out", {56'd0, d_out_m}, 64'h3C);
        check("ovr_lsb_d_out", {56'd0, d_out_l}, {56'd0, rev8(8'h3C)});
        check("ovr_valid", {63'd0, out_valid_m}, 64'h1);
        check("ovr_flag", {63'd0, overrun_m}, 64'h1);
        check("ovr_flag_lsb", {63'd0, overrun_l}, 64'h1);
        expect_word(8'h3C);
        consume();
        check("ovr_sticky", {63'd0, overrun_m}, 64'h1);
        // Clear with a valid bit present: the bit is discarded.
        send_bit(1'b1);
        clear   = 1'b1;
        d_valid = 1'b1;
        d_in    = 1'b1;
        @(posedge clock);
        #1;
        clear   = 1'b0;
        d_valid = 1'b0;
        check("clr_d_out", {56'd0, d_out_m}, 64'h0);
        check("clr_valid", {63'd0, out_valid_m}, 64'h0);
        check("clr_cnt", {61'd0, bit_cnt_m}, 64'h0);
        check("clr_overrun", {63'd0, overrun_m}, 64'h0);

        // Simultaneous completion and ready: 5A held, C3 completes with ready.
        expect_word(8'h5A);
        send_word(8'h5A);
        expect_word(8'hC3);
        pat = 8'hC3;
        for (int i = 7; i >= 1; i--) send_bit(pat[i]);
        out_ready = 1'b1;
        send_bit(pat[0]);
        out_ready = 1'b0;
        check("sim_valid", {63'd0, out_valid_m}, 64'h1);
        check("sim_d_out", {56'd0, d_out_m}, 64'hC3);
        check("sim_overrun", {63'd0, overrun_m}, 64'h0);
        consume();

        // Reset mid-frame after 3 bits.
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        check("mid_cnt_before_rst", {61'd0, bit_cnt_m}, 64'd3);
        reset = 1'b0;
        #1;
        check("mid_rst_cnt_async", {61'd0, bit_cnt_m}, 64'h0);
        check("mid_rst_d_out", {56'd0, d_out_m}, 64'h0);
        idle(1);
        reset = 1'b1;
        idle(1);
        expect_word(8'h81);
        send_word(8'h81);
        check("mid_valid", {63'd0, out_valid_m}, 64'h1);
        check("mid_d_out", {56'd0, d_out_m}, 64'h81);
        check("mid_d_out_lsb", {56'd0, d_out_l}, 64'h81);
        consume();

        idle(3);
        check("msb_queue_drained", 64'(q_m.size()), 64'h0);
        check("lsb_queue_drained", 64'(q_l.size()), 64'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_sipo_framer

// File: doc/sipo_framer.md
# sipo_framer

Parametrised serial-in/parallel-out deframer: the next generation of the 8-bit SIPO with clock counting. It adds configurable word width, configurable bit order, qualified input bits, a counted bit position, and a valid/ready output register with sticky overrun detection. It sits between a 1-bit serial source and a word-wide consumer, and replaces fixed-width SIPOs wherever the consumer can stall.

## Interface
- WIDTH, 8, word width in bits; legal range 2..64
- MSB_FIRST, 1, 1: first received bit lands in d_out[WIDTH-1]; 0: first bit lands in d_out[0]
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- clear  in  1  synchronous clear of frame state, active-high
- d_valid  in  1  qualifies d_in for this cycle
- d_in  in  1  serial data bit
- out_ready  in  1  consumer accepts d_out this cycle
- d_out  out  WIDTH  last completed word
- out_valid  out  1  d_out holds an unconsumed word
- bit_cnt  out  CNT_W  bits of the current frame received so far (0..WIDTH-1)
- overrun  out  1  sticky: a completed word overwrote an unconsumed word

## Operation
- Internal shift register sh[WIDTH-1:0] and counter bit_cnt.
- d_valid=1 at an edge: MSB_FIRST=1 gives sh <= {sh[WIDTH-2:0], d_in}. MSB_FIRST=0 gives sh <= {d_in, sh[WIDTH-1:1]}. bit_cnt increments.
- d_valid=0: sh and bit_cnt hold. Gaps of any length are legal.
- Completion is d_valid=1 with bit_cnt==WIDTH-1:
  - d_out is loaded with the completed word, including the current d_in.
  - out_valid is set.
  - bit_cnt wraps to 0, and sh clears to 0.
- The output register has two states, EMPTY (out_valid=0) and FULL (out_valid=1):
  - EMPTY→FULL on completion.
  - FULL→EMPTY on out_ready=1 with no completion in the same cycle.
  - FULL→FULL on completion. If out_ready=1 in that cycle, it is a normal back-to-back transfer and overrun is unchanged. If out_ready=0, the old word is lost, the new word is loaded, and overrun is set.
- out_ready while EMPTY is ignored.
- d_out is not zeroed when consumed; it holds the last word until the next completion.
- overrun clears only on reset or clear.
- clear has priority over d_valid and out_ready. It sets sh=0, bit_cnt=0, d_out=0, out_valid=0 and overrun=0, and discards the bit sampled that cycle.
- Reset (asynchronous assert, synchronous release) zeroes everything, mid-frame included. A partial frame is discarded.

## Timing
- All outputs are registered. Reset values: d_out=0, out_valid=0, bit_cnt=0, overrun=0.
- Latency: out_valid rises in the cycle after the edge that samples the WIDTH-th valid bit.
- At back-to-back full rate (d_valid tied 1), a new word arrives every WIDTH cycles. The consumer has WIDTH cycles to assert out_ready before an overrun.
- bit_cnt reflects bits already captured and is usable as a frame-position indicator.
- No combinational path exists from any input to any output.

## Structure
- The shared package `sipo_pkg` holds:
  - the CNT_W function, $clog2(WIDTH) with a minimum of 1;
  - the EMPTY/FULL state encoding.
- One sub-module, `sipo_shift_core`, holds the shift register, the bit counter and the completion strobe. The top level holds the output register, the handshake and overrun.
- Instantiation checks: WIDTH < 2 or WIDTH > 64 is a fatal elaboration error.

## Test plan
- MSB-first word: WIDTH=8, MSB_FIRST=1, bits 1,1,1,0,1,1,0,1 with d_valid=1 → d_out=8'hED; out_valid rises one cycle after the 8th bit; overrun=0.
- LSB-first word: same bits with MSB_FIRST=0 → d_out=8'hB7.
- Gapped input: the same 8 bits with d_valid=0 for 3 cycles between bits 4 and 5 → d_out=8'hED; bit_cnt holds at 4 during the gap.
- Overrun: two words 8'hA5 then 8'h3C with out_ready=0 throughout → d_out=8'h3C, out_valid=1, overrun=1. Then assert clear → all outputs 0.
- Simultaneous events: out_ready=1 asserted exactly in the completion cycle of the second word → out_valid stays 1, d_out shows the new word, overrun=0.
- Reset mid-frame: reset asserted after 3 bits, released, then 8 bits of 8'h81 sent → d_out=8'h81. No residue from the partial frame; bit_cnt=0 immediately on reset assertion.
